// File: rtl/median_filter_stream_pkg.sv
// Shared definitions for the streaming median/min/max filter:
// the mode encoding and the helper that locates the median rank.
package median_filter_stream_pkg;

    localparam logic [1:0] MODE_MEDIAN = 2'd0;
    localparam logic [1:0] MODE_MIN    = 2'd1;
    localparam logic [1:0] MODE_MAX    = 2'd2;
    localparam logic [1:0] MODE_BYPASS = 2'd3;

    function automatic int rank_index(input int window_size);
        return (window_size - 1) / 2;
    endfunction

endpackage

// File: rtl/median_rank_select.sv
// Combinational per-channel reduction over one window: median by rank
// selection, unsigned min, unsigned max, or the newest tap in bypass.
module median_rank_select
    import median_filter_stream_pkg::*;
#(
    parameter int WINDOW_SIZE = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic [WINDOW_SIZE*DATA_WIDTH-1:0] taps,
    input  logic [1:0]                        mode,
    output logic [DATA_WIDTH-1:0]             result
);

    localparam int RANK = rank_index(WINDOW_SIZE);

    logic [DATA_WIDTH-1:0] tap [WINDOW_SIZE];
    int                    rank_cnt [WINDOW_SIZE];
    logic [DATA_WIDTH-1:0] median_val;
    logic [DATA_WIDTH-1:0] min_val;
    logic [DATA_WIDTH-1:0] max_val;

    always_comb begin
        for (int i = 0; i < WINDOW_SIZE; i++) begin
            tap[i] = taps[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Equal values are ordered by tap index, so every tap gets a distinct rank.
    always_comb begin
        for (int i = 0; i < WINDOW_SIZE; i++) begin
            rank_cnt[i] = 0;
            for (int j = 0; j < WINDOW_SIZE; j++) begin
                if (j != i && (tap[j] < tap[i] || (tap[j] == tap[i] && j < i))) begin
                    rank_cnt[i] = rank_cnt[i] + 1;
                end
            end
        end
    end

    always_comb begin
        median_val = '0;
        for (int i = 0; i < WINDOW_SIZE; i++) begin
            if (rank_cnt[i] == RANK) begin
                median_val = tap[i];
            end
        end
    end

    always_comb begin
        min_val = tap[0];
        max_val = tap[0];
        for (int i = 1; i < WINDOW_SIZE; i++) begin
            if (tap[i] < min_val) min_val = tap[i];
            if (tap[i] > max_val) max_val = tap[i];
        end
    end

    always_comb begin
        case (mode)
            MODE_MEDIAN: result = median_val;
            MODE_MIN:    result = min_val;
            MODE_MAX:    result = max_val;
            default:     result = tap[0];
        endcase
    end

endmodule

// File: rtl/median_filter_stream.sv
// Two-stage streaming sliding-window filter: S1 holds the window history,
// S2 is the output register feeding a ready/valid downstream.
module median_filter_stream
    import median_filter_stream_pkg::*;
#(
    parameter int WINDOW_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 1,
    localparam int PW         = CHANNELS * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_pixel,
    input  logic          in_sol,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pixel
);

    localparam int              FW        = $clog2(WINDOW_SIZE + 1);
    localparam logic [FW-1:0]   FILL_FULL = FW'(WINDOW_SIZE);

    logic [PW-1:0]                        win [WINDOW_SIZE];
    logic [FW-1:0]                        fill;
    logic [FW-1:0]                        fill_next;
    logic                                 s1_valid;
    logic [1:0]                           s1_mode;
    logic [PW-1:0]                        s1_result;
    logic                                 s2_free;
    logic                                 accept;
    logic [WINDOW_SIZE*DATA_WIDTH-1:0]    ch_taps   [CHANNELS];
    logic [DATA_WIDTH-1:0]                ch_result [CHANNELS];

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        fill_next = fill;
        if (in_sol) begin
            fill_next = FW'(1);
        end else if (fill != FILL_FULL) begin
            fill_next = fill + FW'(1);
        end
    end

    // A start-of-line sample replaces the whole history instead of shifting into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                win[i] <= '0;
            end
            fill     <= '0;
            s1_mode  <= MODE_MEDIAN;
            s1_valid <= 1'b0;
        end else if (accept) begin
            win[0] <= in_pixel;
            for (int i = 1; i < WINDOW_SIZE; i++) begin
                win[i] <= in_sol ? '0 : win[i-1];
            end
            fill     <= fill_next;
            s1_mode  <= mode;
            s1_valid <= (mode == MODE_BYPASS) || (fill_next == FILL_FULL);
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                ch_taps[c][i*DATA_WIDTH +: DATA_WIDTH] = win[i][c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        median_rank_select #(
            .WINDOW_SIZE (WINDOW_SIZE),
            .DATA_WIDTH  (DATA_WIDTH)
        ) u_select (
            .taps   (ch_taps[g]),
            .mode   (s1_mode),
            .result (ch_result[g])
        );
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            s1_result[c*DATA_WIDTH +: DATA_WIDTH] = ch_result[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_pixel <= s1_result;
            end
        end
    end

endmodule

// File: tb/tb_median_filter_stream.sv
// Directed self-checking bench: grayscale W=3 instance for the filter modes,
// flow control and resets, plus an RGB instance for per-channel behaviour.
module tb_median_filter_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pixel = '0;
    logic        in_sol = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_pixel;

    logic        r_in_valid = 1'b0;
    logic        r_in_ready;
    logic [23:0] r_in_pixel = '0;
    logic        r_in_sol = 1'b0;
    logic [1:0]  r_mode = 2'd0;
    logic        r_out_valid;
    logic        r_out_ready = 1'b1;
    logic [23:0] r_out_pixel;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [7:0]  out_q [$];
    int          out_edge_q [$];
    int          acc_edge_q [$];
    logic [23:0] rgb_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    median_filter_stream #(
        .WINDOW_SIZE (3),
        .DATA_WIDTH  (8),
        .CHANNELS    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_sol    (in_sol),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel)
    );

    median_filter_stream #(
        .WINDOW_SIZE (3),
        .DATA_WIDTH  (8),
        .CHANNELS    (3)
    ) dut_rgb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_in_valid),
        .in_ready  (r_in_ready),
        .in_pixel  (r_in_pixel),
        .in_sol    (r_in_sol),
        .mode      (r_mode),
        .out_valid (r_out_valid),
        .out_ready (r_out_ready),
        .out_pixel (r_out_pixel)
    );

    // Handshakes are observed mid-cycle; the recorded edge is the one that completes them.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_q.push_back(out_pixel);
            out_edge_q.push_back(cyc + 1);
        end
        if (!rst && in_valid && in_ready) begin
            acc_edge_q.push_back(cyc + 1);
        end
        if (!rst && r_out_valid && r_out_ready) begin
            rgb_q.push_back(r_out_pixel);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, required the bench to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_queues();
        out_q.delete();
        out_edge_q.delete();
        acc_edge_q.delete();
        rgb_q.delete();
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        clear_queues();
    endtask

    task automatic send(input logic [7:0] pix, input logic sol, input logic [1:0] md);
        logic done;
        done     = 1'b0;
        in_pixel = pix;
        in_sol   = sol;
        mode     = md;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1 done = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_sol   = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL send_timeout: in_ready=%0b, required 1 within 50 cycles", in_ready);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_out_valid: got %0b, expected 0", out_valid);
        end
        n_checks++;
        if (out_pixel !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_out_pixel: got %0d, expected 0", out_pixel);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready: got %0b, expected 1", in_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_queues();
    endtask

    task automatic test_median();
        logic [7:0] stim [5] = '{8'd10, 8'd50, 8'd20, 8'd40, 8'd30};
        logic [7:0] expv [3] = '{8'd20, 8'd40, 8'd30};
        reset_dut();
        for (int i = 0; i < 5; i++) send(stim[i], 1'b0, 2'd0);
        drain(4);
        n_checks++;
        if (out_q.size() !== 3) begin
            n_fail++;
            $display("[TB] FAIL median_count: got %0d results, expected 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== expv[i]) begin
                n_fail++;
                $display("[TB] FAIL median_out%0d: got %0d, expected %0d", i, out_q[i], expv[i]);
            end
        end
        if (out_edge_q.size() > 0 && acc_edge_q.size() > 2) begin
            n_checks++;
            if (out_edge_q[0] !== acc_edge_q[2] + 2) begin
                n_fail++;
                $display("[TB] FAIL median_latency: consumed at edge %0d, expected %0d",
                         out_edge_q[0], acc_edge_q[2] + 2);
            end
        end
    endtask

    task automatic test_min_max_bypass();
        logic [7:0] stim    [5] = '{8'd10, 8'd50, 8'd20, 8'd40, 8'd30};
        logic [7:0] exp_min [3] = '{8'd10, 8'd20, 8'd20};
        logic [7:0] exp_max [3] = '{8'd50, 8'd50, 8'd40};
        for (int m = 1; m <= 3; m++) begin
            reset_dut();
            for (int i = 0; i < 5; i++) send(stim[i], 1'b0, 2'(m));
            drain(4);
            n_checks++;
            if (out_q.size() !== ((m == 3) ? 5 : 3)) begin
                n_fail++;
                $display("[TB] FAIL mode%0d_count: got %0d results, expected %0d",
                         m, out_q.size(), (m == 3) ? 5 : 3);
            end
            for (int i = 0; i < out_q.size() && i < 5; i++) begin
                logic [7:0] e;
                e = (m == 1) ? exp_min[i % 3] : (m == 2) ? exp_max[i % 3] : stim[i];
                n_checks++;
                if (out_q[i] !== e) begin
                    n_fail++;
                    $display("[TB] FAIL mode%0d_out%0d: got %0d, expected %0d", m, i, out_q[i], e);
                end
                if (m == 3 && i < acc_edge_q.size()) begin
                    n_checks++;
                    if (out_edge_q[i] !== acc_edge_q[i] + 2) begin
                        n_fail++;
                        $display("[TB] FAIL bypass_latency%0d: consumed at edge %0d, expected %0d",
                                 i, out_edge_q[i], acc_edge_q[i] + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_mode_change();
        logic [7:0] expv [3] = '{8'd20, 8'd50, 8'd20};
        reset_dut();
        send(8'd10, 1'b0, 2'd0);
        send(8'd50, 1'b0, 2'd0);
        send(8'd20, 1'b0, 2'd0);
        send(8'd40, 1'b0, 2'd2);
        send(8'd30, 1'b0, 2'd1);
        drain(4);
        n_checks++;
        if (out_q.size() !== 3) begin
            n_fail++;
            $display("[TB] FAIL mode_change_count: got %0d results, expected 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== expv[i]) begin
                n_fail++;
                $display("[TB] FAIL mode_change_out%0d: got %0d, expected %0d", i, out_q[i], expv[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] expv [3] = '{8'd20, 8'd40, 8'd30};
        reset_dut();
        out_ready = 1'b0;
        send(8'd10, 1'b0, 2'd0);
        send(8'd50, 1'b0, 2'd0);
        send(8'd20, 1'b0, 2'd0);
        send(8'd40, 1'b0, 2'd0);
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL stall_out_valid: got %0b, expected 1", out_valid);
            end
            n_checks++;
            if (out_pixel !== 8'd20) begin
                n_fail++;
                $display("[TB] FAIL stall_out_pixel: got %0d, expected 20", out_pixel);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_in_ready: got %0b, expected 0", in_ready);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(8'd30, 1'b0, 2'd0);
        drain(4);
        n_checks++;
        if (out_q.size() !== 3) begin
            n_fail++;
            $display("[TB] FAIL stall_count: got %0d results, expected 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== expv[i]) begin
                n_fail++;
                $display("[TB] FAIL stall_out%0d: got %0d, expected %0d", i, out_q[i], expv[i]);
            end
        end
    endtask

    task automatic test_sol();
        reset_dut();
        send(8'd10, 1'b0, 2'd0);
        send(8'd50, 1'b0, 2'd0);
        send(8'd20, 1'b0, 2'd0);
        send(8'd40, 1'b1, 2'd0);
        send(8'd30, 1'b0, 2'd0);
        drain(3);
        n_checks++;
        if (out_q.size() !== 1) begin
            n_fail++;
            $display("[TB] FAIL sol_priming_count: got %0d results, expected 1", out_q.size());
        end
        send(8'd60, 1'b0, 2'd0);
        drain(4);
        n_checks++;
        if (out_q.size() !== 2) begin
            n_fail++;
            $display("[TB] FAIL sol_count: got %0d results, expected 2", out_q.size());
        end
        if (out_q.size() == 2) begin
            n_checks++;
            if (out_q[0] !== 8'd20) begin
                n_fail++;
                $display("[TB] FAIL sol_out0: got %0d, expected 20", out_q[0]);
            end
            n_checks++;
            if (out_q[1] !== 8'd40) begin
                n_fail++;
                $display("[TB] FAIL sol_out1: got %0d, expected 40", out_q[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        send(8'd10, 1'b0, 2'd0);
        send(8'd50, 1'b0, 2'd0);
        send(8'd20, 1'b0, 2'd0);
        send(8'd40, 1'b0, 2'd0);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_out_valid: got %0b, expected 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_out_valid: got %0b, expected 0", out_valid);
        end
        n_checks++;
        if (out_pixel !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL async_out_pixel: got %0d, expected 0", out_pixel);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL async_in_ready: got %0b, expected 1", in_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1 clear_queues();
        send(8'd30, 1'b0, 2'd0);
        send(8'd60, 1'b0, 2'd0);
        drain(4);
        n_checks++;
        if (out_q.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL async_priming_count: got %0d results, expected 0", out_q.size());
        end
        send(8'd90, 1'b0, 2'd0);
        drain(4);
        n_checks++;
        if (out_q.size() !== 1) begin
            n_fail++;
            $display("[TB] FAIL async_restart_count: got %0d results, expected 1", out_q.size());
        end else begin
            n_checks++;
            if (out_q[0] !== 8'd60) begin
                n_fail++;
                $display("[TB] FAIL async_restart_out: got %0d, expected 60", out_q[0]);
            end
        end
    endtask

    task automatic test_rgb();
        logic [23:0] stim [4] = '{24'h050901, 24'h010509, 24'h090105, 24'h020703};
        logic [23:0] expv [2] = '{24'h050505, 24'h020505};
        reset_dut();
        r_mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            logic done;
            done       = 1'b0;
            r_in_pixel = stim[i];
            r_in_valid = 1'b1;
            for (int k = 0; k < 50 && !done; k++) begin
                @(negedge clk);
                if (r_in_ready) begin
                    @(posedge clk);
                    #1 done = 1'b1;
                end
            end
            r_in_valid = 1'b0;
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL rgb_send_timeout: r_in_ready=%0b, required 1", r_in_ready);
            end
        end
        drain(4);
        n_checks++;
        if (rgb_q.size() !== 2) begin
            n_fail++;
            $display("[TB] FAIL rgb_count: got %0d results, expected 2", rgb_q.size());
        end
        for (int i = 0; i < 2 && i < rgb_q.size(); i++) begin
            n_checks++;
            if (rgb_q[i] !== expv[i]) begin
                n_fail++;
                $display("[TB] FAIL rgb_out%0d: got %06h, expected %06h", i, rgb_q[i], expv[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_median();
        test_min_max_bypass();
        test_mode_change();
        test_backpressure();
        test_sol();
        test_async_reset();
        test_rgb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
